// File: rtl/ex_unit.sv
// Purpose: execute stage. It holds an EX latch, computes logic/shift results from it, and holds a MEM latch.
// Latency: the result shows on ex_* in the cycle after the instruction is accepted, and on mem_* one cycle later.
// Backpressure: stall_ex_i holds the EX latch and sends a bubble into MEM; stall_id_i sends a bubble into EX.
//
// Ports:
//   clk, rst                     rising-edge clock; synchronous active-high reset
//   stall_id_i, stall_ex_i       decode / execute stall
//   flush_i                      discard everything in flight
//   aluop_i[7:0], alusel_i[2:0]  operation and result class from decode
//   reg1_i, reg2_i [31:0]        operands; waddr_i[4:0], wreg_i destination
//   ex_wreg_o/ex_waddr_o/ex_wdata_o    combinational EX result (forwarding)
//   mem_wreg_o/mem_waddr_o/mem_wdata_o registered MEM-latch outputs
module ex_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_id_i,
    input  logic        stall_ex_i,
    input  logic        flush_i,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  waddr_i,
    input  logic        wreg_i,
    output logic        ex_wreg_o,
    output logic [4:0]  ex_waddr_o,
    output logic [31:0] ex_wdata_o,
    output logic        mem_wreg_o,
    output logic [4:0]  mem_waddr_o,
    output logic [31:0] mem_wdata_o
);

    localparam logic [7:0] OP_SRL = 8'h02;
    localparam logic [7:0] OP_SRA = 8'h03;
    localparam logic [7:0] OP_AND = 8'h24;
    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_XOR = 8'h26;
    localparam logic [7:0] OP_NOR = 8'h27;
    localparam logic [7:0] OP_SLL = 8'h7C;

    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;

    typedef struct packed {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [4:0]  waddr;
        logic        wreg;
    } ex_lat_t;

    typedef struct packed {
        logic        wreg;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } mem_lat_t;

    ex_lat_t  ex_q;
    mem_lat_t mem_q;

    logic [31:0] logic_res;
    logic [31:0] shift_res;
    logic [4:0]  shamt;

    // Only the low five bits of reg1 form the shift amount.
    assign shamt = ex_q.reg1[4:0];

    always_comb begin
        logic_res = '0;
        case (ex_q.aluop)
            OP_AND:  logic_res = ex_q.reg1 & ex_q.reg2;
            OP_OR:   logic_res = ex_q.reg1 | ex_q.reg2;
            OP_XOR:  logic_res = ex_q.reg1 ^ ex_q.reg2;
            OP_NOR:  logic_res = ~(ex_q.reg1 | ex_q.reg2);
            default: logic_res = '0;
        endcase
    end

    always_comb begin
        shift_res = '0;
        case (ex_q.aluop)
            OP_SLL:  shift_res = ex_q.reg2 << shamt;
            OP_SRL:  shift_res = ex_q.reg2 >> shamt;
            OP_SRA:  shift_res = $signed(ex_q.reg2) >>> shamt;
            default: shift_res = '0;
        endcase
    end

    always_comb begin
        ex_wdata_o = '0;
        case (ex_q.alusel)
            SEL_LOGIC: ex_wdata_o = logic_res;
            SEL_SHIFT: ex_wdata_o = shift_res;
            default:   ex_wdata_o = '0;
        endcase
    end

    // Writes to r0 pass through untouched; the register file discards them.
    assign ex_waddr_o = ex_q.waddr;
    assign ex_wreg_o  = ex_q.wreg;

    // EX latch. Flush beats stall. A stalled EX holds even when decode also stalls.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            ex_q <= '0;
        end else if (stall_ex_i) begin
            ex_q <= ex_q;
        end else if (stall_id_i) begin
            ex_q <= '0;
        end else begin
            ex_q <= '{aluop: aluop_i, alusel: alusel_i, reg1: reg1_i,
                      reg2: reg2_i, waddr: waddr_i, wreg: wreg_i};
        end
    end

    // MEM latch. While EX is held, MEM takes bubbles. This makes the held
    // instruction reach MEM exactly once, on the cycle after the stall ends.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            mem_q <= '0;
        end else if (stall_ex_i) begin
            mem_q <= '0;
        end else begin
            mem_q <= '{wreg: ex_wreg_o, waddr: ex_waddr_o, wdata: ex_wdata_o};
        end
    end

    assign mem_wreg_o  = mem_q.wreg;
    assign mem_waddr_o = mem_q.waddr;
    assign mem_wdata_o = mem_q.wdata;

endmodule

// File: tb/tb_ex_unit.sv
// Purpose: directed self-checking bench for ex_unit.
// Latency: inputs are driven 1ns after a rising edge, and outputs are checked 1ns after the next edge.
// Backpressure: the stall and flush scenarios are driven explicitly by the tasks below.
module tb_ex_unit;

    logic        clk = 1'b0;
    logic        rst, stall_id_i, stall_ex_i, flush_i;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  waddr_i;
    logic        wreg_i;
    logic        ex_wreg_o, mem_wreg_o;
    logic [4:0]  ex_waddr_o, mem_waddr_o;
    logic [31:0] ex_wdata_o, mem_wdata_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ex_unit dut (
        .clk(clk), .rst(rst), .stall_id_i(stall_id_i), .stall_ex_i(stall_ex_i),
        .flush_i(flush_i), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .waddr_i(waddr_i), .wreg_i(wreg_i),
        .ex_wreg_o(ex_wreg_o), .ex_waddr_o(ex_waddr_o), .ex_wdata_o(ex_wdata_o),
        .mem_wreg_o(mem_wreg_o), .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o)
    );

    // Bundled views of the outputs: {wreg, waddr, wdata}.
    wire [37:0] ex_v  = {ex_wreg_o, ex_waddr_o, ex_wdata_o};
    wire [37:0] mem_v = {mem_wreg_o, mem_waddr_o, mem_wdata_o};

    task automatic instr(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [4:0] wa, input logic we);
        aluop_i = op; alusel_i = sel; reg1_i = r1; reg2_i = r2; waddr_i = wa; wreg_i = we;
    endtask

    task automatic nop();
        instr(8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall_id_i = 0; stall_ex_i = 0; flush_i = 0;
        instr(8'h25, 3'b001, 32'hFFFF_FFFF, 32'h1, 5'd4, 1'b1);
        tick(); tick();
        n_chk++;
        if ({ex_v, mem_v} !== 76'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", {ex_v, mem_v});
        end
        rst = 1'b0;
        nop();
        tick();
    endtask

    task automatic test_or();
        instr(8'h25, 3'b001, 32'h0000_FF00, 32'h0000_00FF, 5'd3, 1'b1);
        tick();
        n_chk++;
        if (ex_v !== {1'b1, 5'd3, 32'h0000_FFFF}) begin
            n_fail++; $display("FAIL or_ex: got %h expected %h", ex_v, {1'b1, 5'd3, 32'h0000_FFFF});
        end
        instr(8'h25, 3'b000, 32'hFFFF_FFFF, 32'h1, 5'd6, 1'b0);   // alusel NOP, wreg=0
        tick();
        n_chk++;
        if (mem_v !== {1'b1, 5'd3, 32'h0000_FFFF}) begin
            n_fail++; $display("FAIL or_mem: got %h expected %h", mem_v, {1'b1, 5'd3, 32'h0000_FFFF});
        end
        n_chk++;
        if ({ex_wreg_o, ex_wdata_o} !== 33'h0) begin
            n_fail++; $display("FAIL nop_sel_ex: got %h expected 0", {ex_wreg_o, ex_wdata_o});
        end
    endtask

    task automatic test_shift();
        instr(8'h03, 3'b010, 32'h0000_0024, 32'h8000_0000, 5'd5, 1'b1);   // SRA
        tick();
        n_chk++;
        if (ex_wdata_o !== 32'hF800_0000) begin
            n_fail++; $display("FAIL sra: got %h expected %h", ex_wdata_o, 32'hF800_0000);
        end
        instr(8'h02, 3'b010, 32'h0000_0024, 32'h8000_0000, 5'd6, 1'b1);   // SRL
        tick();
        n_chk++;
        if (ex_wdata_o !== 32'h0800_0000) begin
            n_fail++; $display("FAIL srl: got %h expected %h", ex_wdata_o, 32'h0800_0000);
        end
        n_chk++;
        if (mem_v !== {1'b1, 5'd5, 32'hF800_0000}) begin
            n_fail++; $display("FAIL sra_mem: got %h expected %h", mem_v, {1'b1, 5'd5, 32'hF800_0000});
        end
        instr(8'h7C, 3'b010, 32'hFFFF_FFE4, 32'h0000_0001, 5'd7, 1'b1);   // SLL, reg1 upper bits ignored
        tick();
        n_chk++;
        if (ex_wdata_o !== 32'h0000_0010) begin
            n_fail++; $display("FAIL sll_upper_ignored: got %h expected %h", ex_wdata_o, 32'h0000_0010);
        end
        instr(8'h03, 3'b010, 32'h0000_0004, 32'h7000_0000, 5'd7, 1'b1);   // SRA with a positive value
        tick();
        n_chk++;
        if (ex_wdata_o !== 32'h0700_0000) begin
            n_fail++; $display("FAIL sra_pos: got %h expected %h", ex_wdata_o, 32'h0700_0000);
        end
        instr(8'h24, 3'b010, 32'h0000_0004, 32'hFFFF_FFFF, 5'd7, 1'b1);   // non-shift op in SHIFT class
        tick();
        n_chk++;
        if (ex_wdata_o !== 32'h0) begin
            n_fail++; $display("FAIL shift_other_op: got %h expected 0", ex_wdata_o);
        end
    endtask

    task automatic test_logic();
        instr(8'h27, 3'b001, 32'h0, 32'h0, 5'd8, 1'b1);
        tick();
        n_chk++;
        if (ex_wdata_o !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL nor: got %h expected %h", ex_wdata_o, 32'hFFFF_FFFF);
        end
        instr(8'h24, 3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd8, 1'b1);
        tick();
        n_chk++;
        if (ex_wdata_o !== 32'hF000_F000) begin
            n_fail++; $display("FAIL and: got %h expected %h", ex_wdata_o, 32'hF000_F000);
        end
        instr(8'h26, 3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd8, 1'b1);
        tick();
        n_chk++;
        if (ex_wdata_o !== 32'h0FF0_0FF0) begin
            n_fail++; $display("FAIL xor: got %h expected %h", ex_wdata_o, 32'h0FF0_0FF0);
        end
        instr(8'h02, 3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd8, 1'b1);   // non-logic op in LOGIC class
        tick();
        n_chk++;
        if (ex_wdata_o !== 32'h0) begin
            n_fail++; $display("FAIL logic_other_op: got %h expected 0", ex_wdata_o);
        end
        instr(8'h25, 3'b001, 32'h1, 32'h2, 5'd0, 1'b1);   // write to r0 passes through unchanged
        tick();
        n_chk++;
        if (ex_v !== {1'b1, 5'd0, 32'h3}) begin
            n_fail++; $display("FAIL r0_write: got %h expected %h", ex_v, {1'b1, 5'd0, 32'h3});
        end
        nop();
        tick();
    endtask

    task automatic test_stall_ex();
        instr(8'h25, 3'b001, 32'h1234_0000, 32'h0000_5678, 5'd7, 1'b1);   // A
        tick();
        stall_ex_i = 1'b1;
        instr(8'h26, 3'b001, 32'h0000_00FF, 32'h0000_000F, 5'd9, 1'b1);   // B waits on input
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (ex_v !== {1'b1, 5'd7, 32'h1234_5678}) begin
                n_fail++; $display("FAIL stall_ex_hold[%0d]: got %h expected %h", i, ex_v, {1'b1, 5'd7, 32'h1234_5678});
            end
            n_chk++;
            if (mem_wreg_o !== 1'b0) begin
                n_fail++; $display("FAIL stall_ex_mem_bubble[%0d]: got %b expected 0", i, mem_wreg_o);
            end
        end
        stall_ex_i = 1'b0;
        tick();
        n_chk++;
        if (mem_v !== {1'b1, 5'd7, 32'h1234_5678}) begin
            n_fail++; $display("FAIL stall_release_mem: got %h expected %h", mem_v, {1'b1, 5'd7, 32'h1234_5678});
        end
        n_chk++;
        if (ex_v !== {1'b1, 5'd9, 32'h0000_00F0}) begin
            n_fail++; $display("FAIL stall_release_ex: got %h expected %h", ex_v, {1'b1, 5'd9, 32'h0000_00F0});
        end
        nop();
        tick();
        n_chk++;
        if (mem_v !== {1'b1, 5'd9, 32'h0000_00F0}) begin
            n_fail++; $display("FAIL stall_no_dup: got %h expected %h", mem_v, {1'b1, 5'd9, 32'h0000_00F0});
        end
    endtask

    task automatic test_stall_id();
        instr(8'h25, 3'b001, 32'hA000_0000, 32'h0000_000A, 5'd10, 1'b1);  // C
        tick();
        stall_id_i = 1'b1;
        instr(8'h25, 3'b001, 32'h1, 32'h1, 5'd11, 1'b1);                  // D not offered
        tick();
        n_chk++;
        if (ex_v !== 38'h0) begin
            n_fail++; $display("FAIL stall_id_bubble: got %h expected 0", ex_v);
        end
        n_chk++;
        if (mem_v !== {1'b1, 5'd10, 32'hA000_000A}) begin
            n_fail++; $display("FAIL stall_id_advance: got %h expected %h", mem_v, {1'b1, 5'd10, 32'hA000_000A});
        end
        stall_id_i = 1'b0;
        nop();
        tick();
        n_chk++;
        if (mem_wreg_o !== 1'b0) begin
            n_fail++; $display("FAIL stall_id_mem_bubble: got %b expected 0", mem_wreg_o);
        end
    endtask

    task automatic test_both_stalls();
        instr(8'h24, 3'b001, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd12, 1'b1);  // E
        tick();
        stall_ex_i = 1'b1; stall_id_i = 1'b1;
        nop();
        tick();
        n_chk++;
        if (ex_v !== {1'b1, 5'd12, 32'h0F0F_0000}) begin
            n_fail++; $display("FAIL both_stall_hold: got %h expected %h", ex_v, {1'b1, 5'd12, 32'h0F0F_0000});
        end
        stall_ex_i = 1'b0; stall_id_i = 1'b0;
        tick();
        n_chk++;
        if (mem_v !== {1'b1, 5'd12, 32'h0F0F_0000}) begin
            n_fail++; $display("FAIL both_stall_release: got %h expected %h", mem_v, {1'b1, 5'd12, 32'h0F0F_0000});
        end
    endtask

    task automatic test_flush();
        instr(8'h25, 3'b001, 32'h1, 32'h0, 5'd13, 1'b1);   // F
        tick();
        instr(8'h25, 3'b001, 32'h2, 32'h0, 5'd14, 1'b1);   // G
        tick();
        flush_i = 1'b1; stall_ex_i = 1'b1;                  // flush must beat the stall
        instr(8'h25, 3'b001, 32'h4, 32'h0, 5'd15, 1'b1);   // H
        tick();
        n_chk++;
        if ({ex_v, mem_v} !== 76'h0) begin
            n_fail++; $display("FAIL flush_clear: got %h expected 0", {ex_v, mem_v});
        end
        flush_i = 1'b0; stall_ex_i = 1'b0;
        tick();
        n_chk++;
        if (ex_v !== {1'b1, 5'd15, 32'h4}) begin
            n_fail++; $display("FAIL flush_next_ex: got %h expected %h", ex_v, {1'b1, 5'd15, 32'h4});
        end
        nop();
        tick();
        n_chk++;
        if (mem_v !== {1'b1, 5'd15, 32'h4}) begin
            n_fail++; $display("FAIL flush_next_mem: got %h expected %h", mem_v, {1'b1, 5'd15, 32'h4});
        end
    endtask

    task automatic test_reset_mid_stall();
        instr(8'h25, 3'b001, 32'h8, 32'h0, 5'd16, 1'b1);   // I
        tick();
        instr(8'h25, 3'b001, 32'h10, 32'h0, 5'd17, 1'b1);  // J: I in MEM, J in EX
        tick();
        stall_ex_i = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        n_chk++;
        if ({ex_v, mem_v} !== 76'h0) begin
            n_fail++; $display("FAIL rst_mid_stall: got %h expected 0", {ex_v, mem_v});
        end
        rst = 1'b0; stall_ex_i = 1'b0;
        nop();
        tick();
        n_chk++;
        if ({ex_v, mem_v} !== 76'h0) begin
            n_fail++; $display("FAIL rst_no_residue: got %h expected 0", {ex_v, mem_v});
        end
        instr(8'h26, 3'b001, 32'h0000_00F0, 32'h0000_0FF0, 5'd18, 1'b1);
        tick();
        nop();
        tick();
        n_chk++;
        if (mem_v !== {1'b1, 5'd18, 32'h0000_0F00}) begin
            n_fail++; $display("FAIL rst_next_flow: got %h expected %h", mem_v, {1'b1, 5'd18, 32'h0000_0F00});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_or();
        test_shift();
        test_logic();
        test_stall_ex();
        test_stall_id();
        test_both_stalls();
        test_flush();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
